// File: rtl/debug_trace_serializer.sv
// Serialises N-lane retirement records onto the single-lane debug_wb_* trace port.
// Optional macro DEBUG_TRACE_KEEP_NOWB_EN keeps records with a zero write strobe.
module debug_trace_serializer #(
    parameter int LANES = 2,
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [LANES-1:0]      commit_valid,
    input  logic [32*LANES-1:0]   commit_pc,
    input  logic [4*LANES-1:0]    commit_wen,
    input  logic [5*LANES-1:0]    commit_wnum,
    input  logic [32*LANES-1:0]   commit_wdata,
    output logic                  commit_ready,
    output logic [31:0]           debug_wb_pc,
    output logic [3:0]            debug_wb_rf_wen,
    output logic [4:0]            debug_wb_rf_wnum,
    output logic [31:0]           debug_wb_rf_wdata,
    output logic                  trace_empty
);

    localparam logic [PTR_W:0] READY_MAX = (PTR_W+1)'(DEPTH - LANES);

    logic [31:0]      mem_pc    [DEPTH];
    logic [3:0]       mem_wen   [DEPTH];
    logic [4:0]       mem_wnum  [DEPTH];
    logic [31:0]      mem_wdata [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   pushed;
    logic [PTR_W:0]   popped;
    logic [LANES-1:0] keep;
    logic [PTR_W-1:0] slot [LANES];

    // Readiness ignores the pop of this cycle, so a full group always fits.
    assign commit_ready = (count <= READY_MAX);
    assign popped       = {{PTR_W{1'b0}}, (count != '0)};

    // Kept lanes are packed: each one lands at tail plus the number of kept lanes below it.
    always_comb begin
        keep   = '0;
        pushed = '0;
        for (int i = 0; i < LANES; i++) begin
            slot[i] = pushed[PTR_W-1:0];
`ifdef DEBUG_TRACE_KEEP_NOWB_EN
            keep[i] = commit_valid[i];
`else
            keep[i] = commit_valid[i] && (commit_wen[4*i +: 4] != 4'd0);
`endif
            if (commit_ready && keep[i]) begin
                pushed = pushed + (PTR_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (commit_ready && keep[i]) begin
                mem_pc   [tail + slot[i]] <= commit_pc   [32*i +: 32];
                mem_wen  [tail + slot[i]] <= commit_wen  [4*i  +: 4];
                mem_wnum [tail + slot[i]] <= commit_wnum [5*i  +: 5];
                mem_wdata[tail + slot[i]] <= commit_wdata[32*i +: 32];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head              <= '0;
            tail              <= '0;
            count             <= '0;
            debug_wb_pc       <= '0;
            debug_wb_rf_wen   <= '0;
            debug_wb_rf_wnum  <= '0;
            debug_wb_rf_wdata <= '0;
        end else begin
            tail  <= tail + pushed[PTR_W-1:0];
            count <= count + pushed - popped;
            if (count != '0) begin
                debug_wb_pc       <= mem_pc   [head];
                debug_wb_rf_wen   <= mem_wen  [head];
                debug_wb_rf_wnum  <= mem_wnum [head];
                debug_wb_rf_wdata <= mem_wdata[head];
                head              <= head + PTR_W'(1);
            end else begin
                debug_wb_rf_wen   <= 4'd0;
            end
        end
    end

`ifdef DEBUG_TRACE_KEEP_NOWB_EN
    // A kept record may carry wen == 0, so emptiness tracks whether a pop happened instead.
    logic out_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= (count != '0);
        end
    end

    assign trace_empty = (count == '0) && !out_valid;
`else
    assign trace_empty = (count == '0) && (debug_wb_rf_wen == 4'd0);
`endif

endmodule

// File: tb/tb_debug_trace_serializer.sv
// Directed self-checking bench for debug_trace_serializer (LANES=2, DEPTH=8).
module tb_debug_trace_serializer;

    localparam int LANES = 2;
    localparam int DEPTH = 8;

    logic                clk;
    logic                reset;
    logic [LANES-1:0]    commit_valid;
    logic [32*LANES-1:0] commit_pc;
    logic [4*LANES-1:0]  commit_wen;
    logic [5*LANES-1:0]  commit_wnum;
    logic [32*LANES-1:0] commit_wdata;
    logic                commit_ready;
    logic [31:0]         debug_wb_pc;
    logic [3:0]          debug_wb_rf_wen;
    logic [4:0]          debug_wb_rf_wnum;
    logic [31:0]         debug_wb_rf_wdata;
    logic                trace_empty;

    int n_tests = 0;
    int n_fail  = 0;

    int g, cyc, rdy, ready_run, stalled;
    int k, mcyc;

    debug_trace_serializer #(.LANES(LANES), .DEPTH(DEPTH)) dut (
        .clk               (clk),
        .reset             (reset),
        .commit_valid      (commit_valid),
        .commit_pc         (commit_pc),
        .commit_wen        (commit_wen),
        .commit_wnum       (commit_wnum),
        .commit_wdata      (commit_wdata),
        .commit_ready      (commit_ready),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata),
        .trace_empty       (trace_empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_rec(input string tag, input logic [31:0] pc, input logic [3:0] wen,
                           input logic [4:0] wnum, input logic [31:0] wdata);
        chk({tag, ".pc"},    debug_wb_pc,              pc);
        chk({tag, ".wen"},   {28'd0, debug_wb_rf_wen}, {28'd0, wen});
        chk({tag, ".wnum"},  {27'd0, debug_wb_rf_wnum}, {27'd0, wnum});
        chk({tag, ".wdata"}, debug_wb_rf_wdata,        wdata);
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_lane(input int i, input logic [31:0] pc, input logic [3:0] wen,
                            input logic [4:0] wnum, input logic [31:0] wdata);
        commit_valid[i]          = 1'b1;
        commit_pc[32*i +: 32]    = pc;
        commit_wen[4*i +: 4]     = wen;
        commit_wnum[5*i +: 5]    = wnum;
        commit_wdata[32*i +: 32] = wdata;
    endtask

    task automatic clear_lanes;
        commit_valid = '0;
    endtask

    // Group n carries records 2n and 2n+1: pc 0x1000+4r, wnum r+1, wdata 0x5000+r.
    task automatic set_group(input int n);
        set_lane(0, 32'h1000 + 32'(8*n),     4'hF, 5'(2*n + 1), 32'h5000 + 32'(2*n));
        set_lane(1, 32'h1000 + 32'(8*n + 4), 4'hF, 5'(2*n + 2), 32'h5000 + 32'(2*n + 1));
    endtask

    initial begin
        reset        = 1'b1;
        commit_valid = '0;
        commit_pc    = '0;
        commit_wen   = '0;
        commit_wnum  = '0;
        commit_wdata = '0;
        @(negedge clk);
        @(negedge clk);
        chk_rec("rst", 32'h0, 4'h0, 5'd0, 32'h0);
        chk("rst.ready", {31'd0, commit_ready}, 32'd1);
        chk("rst.empty", {31'd0, trace_empty}, 32'd1);
        reset = 1'b0;

        // single commit: visible only after the second edge
        set_lane(0, 32'hBFC00000, 4'hF, 5'd3, 32'h1234);
        tick;
        clear_lanes();
        chk("t1.latency_wen", {28'd0, debug_wb_rf_wen}, 32'd0);
        chk("t1.not_empty", {31'd0, trace_empty}, 32'd0);
        tick;
        chk_rec("t1", 32'hBFC00000, 4'hF, 5'd3, 32'h1234);
        tick;
        chk("t1.after_wen", {28'd0, debug_wb_rf_wen}, 32'd0);
        chk("t1.after_empty", {31'd0, trace_empty}, 32'd1);

        // dual commit in lane order
        set_lane(0, 32'h100, 4'hF, 5'd1, 32'hA);
        set_lane(1, 32'h104, 4'hF, 5'd2, 32'hB);
        tick;
        clear_lanes();
        chk("t2.latency_wen", {28'd0, debug_wb_rf_wen}, 32'd0);
        tick;
        chk_rec("t2.r1", 32'h100, 4'hF, 5'd1, 32'hA);
        tick;
        chk_rec("t2.r2", 32'h104, 4'hF, 5'd2, 32'hB);
        tick;
        chk("t2.after_wen", {28'd0, debug_wb_rf_wen}, 32'd0);
        chk("t2.after_empty", {31'd0, trace_empty}, 32'd1);

        // back-pressure: both lanes every cycle, ten groups
        fork
            begin
                g = 0; cyc = 0; ready_run = 0; stalled = 0;
                set_group(0);
                while (g < 10 && cyc < 300) begin
                    rdy = int'(commit_ready);
                    if (rdy == 0) stalled = 1;
                    else if (stalled == 0) ready_run++;
                    tick;
                    cyc++;
                    if (rdy != 0) begin
                        g++;
                        if (g < 10) set_group(g);
                        else clear_lanes();
                    end
                end
                clear_lanes();
                chk("bp.groups_accepted", g, 10);
            end
            begin
                k = 0; mcyc = 0;
                while (k < 20 && mcyc < 300) begin
                    @(negedge clk);
                    mcyc++;
                    if (debug_wb_rf_wen != 4'd0) begin
                        chk("bp.pc",    debug_wb_pc,       32'h1000 + 32'(4*k));
                        chk("bp.wnum",  {27'd0, debug_wb_rf_wnum}, 32'(k + 1));
                        chk("bp.wdata", debug_wb_rf_wdata, 32'h5000 + 32'(k));
                        k++;
                    end
                end
                chk("bp.records_out", k, 20);
            end
        join
        chk("bp.ready_run", ready_run, 6);
        chk("bp.stalled", stalled, 1);
        tick;
        chk("bp.drain_empty", {31'd0, trace_empty}, 32'd1);
        chk("bp.drain_ready", {31'd0, commit_ready}, 32'd1);

        // filter: lane0 is a store with no register write
        set_lane(0, 32'h200, 4'h0, 5'd0, 32'h0);
        set_lane(1, 32'h204, 4'hF, 5'd5, 32'h55);
        tick;
        clear_lanes();
        chk("t4.latency_wen", {28'd0, debug_wb_rf_wen}, 32'd0);
        chk("t4.not_empty", {31'd0, trace_empty}, 32'd0);
        tick;
`ifdef DEBUG_TRACE_KEEP_NOWB_EN
        chk_rec("t4.store", 32'h200, 4'h0, 5'd0, 32'h0);
        chk("t4.store_not_empty", {31'd0, trace_empty}, 32'd0);
        tick;
        chk_rec("t4.r5", 32'h204, 4'hF, 5'd5, 32'h55);
`else
        chk_rec("t4.r5", 32'h204, 4'hF, 5'd5, 32'h55);
`endif
        tick;
        chk("t4.after_wen", {28'd0, debug_wb_rf_wen}, 32'd0);
        chk("t4.after_empty", {31'd0, trace_empty}, 32'd1);

        // lane gap: only lane1 valid; lane0 fields look like a real record but must be ignored
        commit_pc[31:0]   = 32'h2F0;
        commit_wen[3:0]   = 4'hF;
        commit_wnum[4:0]  = 5'd9;
        commit_wdata[31:0] = 32'h99;
        set_lane(1, 32'h300, 4'hF, 5'd7, 32'h77);
        tick;
        clear_lanes();
        tick;
        chk_rec("t5", 32'h300, 4'hF, 5'd7, 32'h77);
        tick;
        chk("t5.after_wen", {28'd0, debug_wb_rf_wen}, 32'd0);
        chk("t5.after_empty", {31'd0, trace_empty}, 32'd1);

        // async reset with five entries buffered
        for (int n = 0; n < 4; n++) begin
            set_lane(0, 32'h7000 + 32'(8*n),     4'hF, 5'(10 + 2*n), 32'h70 + 32'(2*n));
            set_lane(1, 32'h7000 + 32'(8*n + 4), 4'hF, 5'(11 + 2*n), 32'h71 + 32'(2*n));
            tick;
        end
        clear_lanes();
        chk_rec("t6.pre", 32'h7008, 4'hF, 5'd12, 32'h72);
        chk("t6.pre_ready", {31'd0, commit_ready}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk_rec("t6.rst", 32'h0, 4'h0, 5'd0, 32'h0);
        chk("t6.rst_ready", {31'd0, commit_ready}, 32'd1);
        chk("t6.rst_empty", {31'd0, trace_empty}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        for (int n = 0; n < 4; n++) begin
            tick;
            chk("t6.no_stale_wen", {28'd0, debug_wb_rf_wen}, 32'd0);
            chk("t6.no_stale_empty", {31'd0, trace_empty}, 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
